// File: rtl/image_gen_pkg.sv
// Shared types and constants for the image_gen frame-synchronised configuration path.
package image_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam int NUM_REGS_DEF = 4;
    localparam int DATA_W_DEF   = 32;

    // Register map shared by software and the pixel generator
    localparam int PADDLE_L = 0;
    localparam int PADDLE_R = 1;
    localparam int BALL_XY  = 2;
    localparam int COLOR    = 3;

endpackage

// File: rtl/image_gen_reg_bank.sv
// Byte-strobed staging register bank with all registers read out in parallel.
module image_gen_reg_bank
    import image_gen_pkg::*;
#(
    parameter int                NUM_REGS  = NUM_REGS_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/8-1:0]          wr_strb,
    output logic [NUM_REGS*DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // NOTE: this small bank is reset explicitly because software reads back known values after reset; large RAMs normally would not be.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_rd
        assign rd_data[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: rtl/image_gen_frame_sync_ctrl.sv
// Double-buffered config controller: staged writes reach the live bank only at an armed frame start.
module image_gen_frame_sync_ctrl
    import image_gen_pkg::*;
#(
    parameter int                NUM_REGS  = NUM_REGS_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [$clog2(NUM_REGS)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/8-1:0]          wr_strb,
    input  logic                         commit_req,
    input  logic                         vsync_start,
    input  logic                         irq_clr,
    output logic [NUM_REGS*DATA_W-1:0]   shadow_regs,
    output logic                         pending,
    output logic                         commit_done,
    output logic                         irq,
    output logic [CNT_W-1:0]             frame_cnt
);

    state_t                       state;
    logic                         wr_fire;
    logic [NUM_REGS*DATA_W-1:0]   staging;
    logic [DATA_W-1:0]            shadow [NUM_REGS];

    // wr_ready is a registered copy of (state == IDLE), so the staging bank is frozen while armed
    assign wr_fire = wr_valid && wr_ready;

    image_gen_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_staging (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_data (staging)
    );

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state       <= IDLE;
            wr_ready    <= 1'b1;
            pending     <= 1'b0;
            commit_done <= 1'b0;
            irq         <= 1'b0;
            frame_cnt   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= RESET_VAL;
            end
        end else begin
            commit_done <= 1'b0;
            if (irq_clr) begin
                irq <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (commit_req) begin
                        state    <= ARMED;
                        wr_ready <= 1'b0;
                        pending  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (vsync_start) begin
                        state       <= APPLY;
                        commit_done <= 1'b1;
                        frame_cnt   <= frame_cnt + CNT_W'(1);
                        irq         <= 1'b1;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            shadow[i] <= staging[i*DATA_W +: DATA_W];
                        end
                    end
                end
                APPLY: begin
                    // Re-asserting irq here makes a clear during the APPLY cycle lose to the set
                    state    <= IDLE;
                    wr_ready <= 1'b1;
                    pending  <= 1'b0;
                    irq      <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    wr_ready <= 1'b1;
                    pending  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_shadow
        assign shadow_regs[g*DATA_W +: DATA_W] = shadow[g];
    end

endmodule

// File: tb/tb_image_gen_frame_sync_ctrl.sv
// Scoreboard bench: vsync stimulus queues the expected live bank, a monitor checks it on commit_done.
module tb_image_gen_frame_sync_ctrl;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int CW = 4;

    logic              ACLK;
    logic              ARESETN;
    logic              wr_valid;
    logic              wr_ready;
    logic [1:0]        wr_addr;
    logic [DW-1:0]     wr_data;
    logic [DW/8-1:0]   wr_strb;
    logic              commit_req;
    logic              vsync_start;
    logic              irq_clr;
    logic [NR*DW-1:0]  shadow_regs;
    logic              pending;
    logic              commit_done;
    logic              irq;
    logic [CW-1:0]     frame_cnt;

    image_gen_frame_sync_ctrl #(
        .NUM_REGS  (NR),
        .DATA_W    (DW),
        .RESET_VAL ('0),
        .CNT_W     (CW)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .commit_req  (commit_req),
        .vsync_start (vsync_start),
        .irq_clr     (irq_clr),
        .shadow_regs (shadow_regs),
        .pending     (pending),
        .commit_done (commit_done),
        .irq         (irq),
        .frame_cnt   (frame_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [NR*DW-1:0] shadow;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic          prev_done = 1'b0;
    int            assert_cnt = 0;
    int            fail_cnt = 0;
    logic [DW-1:0] mstage [NR];
    logic [CW-1:0] model_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] sreg(input int i);
        return shadow_regs[i*DW +: DW];
    endfunction

    function automatic logic [NR*DW-1:0] mflat();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = mstage[i];
        return r;
    endfunction

    // Monitor: every commit_done must match the oldest queued expectation and last one cycle
    always @(negedge ACLK) begin
        if (prev_done) check("commit_done_one_cycle", commit_done, 1'b0);
        if (commit_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_commit_done", commit_done, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("apply_shadow", shadow_regs, mon_e.shadow);
                check("apply_frame_cnt", frame_cnt, mon_e.cnt);
                check("apply_irq", irq, 1'b1);
                check("apply_pending", pending, 1'b1);
                check("apply_wr_ready", wr_ready, 1'b0);
            end
        end
        prev_done = (commit_done === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mstage[i] = '0;
        model_cnt = '0;
    endtask

    task automatic write_reg(input int addr, input logic [DW-1:0] data, input logic [3:0] strb);
        bit ok;
        ok = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = addr[1:0];
        wr_data  = data;
        wr_strb  = strb;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge ACLK);
            ok = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        check("write_accepted", ok, 1'b1);
        if (ok) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mstage[addr][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic pulse_vsync(input bit expect_commit);
        exp_t e;
        if (expect_commit) begin
            model_cnt = model_cnt + 1'b1;
            e.shadow  = mflat();
            e.cnt     = model_cnt;
            exp_q.push_back(e);
        end
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
    endtask

    initial begin
        ARESETN = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        commit_req = 1'b0; vsync_start = 1'b0; irq_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        ARESETN = 1'b1;

        @(negedge ACLK);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_pending", pending, 1'b0);
        check("rst_commit_done", commit_done, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_frame_cnt", frame_cnt, 4'd0);
        check("rst_shadow", shadow_regs, 128'd0);

        // Staged write without a commit never reaches the live bank
        write_reg(1, 32'hDEADBEEF, 4'hF);
        pulse_vsync(1'b0);
        repeat (3) tick();
        pulse_vsync(1'b0);
        repeat (3) tick();
        @(negedge ACLK);
        check("nocommit_reg1", sreg(1), 32'h0);
        check("nocommit_frame_cnt", frame_cnt, 4'd0);

        // Basic commit
        write_reg(0, 32'h00010002, 4'hF);
        commit();
        @(negedge ACLK);
        check("armed_pending", pending, 1'b1);
        check("armed_wr_ready", wr_ready, 1'b0);
        repeat (20) tick();
        pulse_vsync(1'b1);
        repeat (2) tick();
        @(negedge ACLK);
        check("basic_reg0", sreg(0), 32'h00010002);
        check("basic_irq", irq, 1'b1);
        check("basic_frame_cnt", frame_cnt, 4'd1);
        check("basic_pending", pending, 1'b0);

        // Byte strobes
        write_reg(2, 32'h11223344, 4'hF);
        write_reg(2, 32'hAABBCCDD, 4'h5);
        commit();
        repeat (2) tick();
        pulse_vsync(1'b1);
        repeat (2) tick();
        @(negedge ACLK);
        check("strobe_reg2", sreg(2), 32'h11BB33DD);

        // Write stalls while armed and lands after the commit
        commit();
        fork
            write_reg(3, 32'h00000055, 4'hF);
            begin
                repeat (3) tick();
                @(negedge ACLK);
                check("stall_wr_ready", wr_ready, 1'b0);
                check("stall_reg3_staged_only", sreg(3), 32'h0);
                tick();
                pulse_vsync(1'b1);
            end
        join
        repeat (2) tick();
        @(negedge ACLK);
        check("stall_old_reg3", sreg(3), 32'h0);
        commit();
        pulse_vsync(1'b1);
        repeat (2) tick();
        @(negedge ACLK);
        check("stall_new_reg3", sreg(3), 32'h00000055);
        check("stall_frame_cnt", frame_cnt, 4'd4);

        // irq clear, then commit_req together with vsync_start
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        @(negedge ACLK);
        check("irq_cleared", irq, 1'b0);
        write_reg(0, 32'h00030004, 4'hF);
        commit_req = 1'b1;
        vsync_start = 1'b1;
        tick();
        commit_req = 1'b0;
        vsync_start = 1'b0;
        repeat (3) tick();
        @(negedge ACLK);
        check("samecycle_reg0_unchanged", sreg(0), 32'h00010002);
        check("samecycle_still_armed", pending, 1'b1);
        pulse_vsync(1'b1);
        irq_clr = 1'b1;
        commit_req = 1'b1;
        tick();
        irq_clr = 1'b0;
        commit_req = 1'b0;
        @(negedge ACLK);
        check("set_beats_clr_irq", irq, 1'b1);
        check("apply_commit_ignored", pending, 1'b0);
        check("next_vsync_reg0", sreg(0), 32'h00030004);
        check("next_vsync_frame_cnt", frame_cnt, 4'd5);

        // Reset while armed aborts the commit
        write_reg(1, 32'h12345678, 4'hF);
        commit();
        ARESETN = 1'b0;
        tick();
        ARESETN = 1'b1;
        model_reset();
        @(negedge ACLK);
        check("abort_pending", pending, 1'b0);
        check("abort_shadow", shadow_regs, 128'd0);
        check("abort_frame_cnt", frame_cnt, 4'd0);
        check("abort_irq", irq, 1'b0);
        pulse_vsync(1'b0);
        repeat (3) tick();

        // 16 commits wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            write_reg(0, 32'(i + 1), 4'hF);
            commit();
            tick();
            pulse_vsync(1'b1);
            repeat (2) tick();
            if (i == 14) begin
                @(negedge ACLK);
                check("wrap_cnt_15", frame_cnt, 4'd15);
            end
        end
        @(negedge ACLK);
        check("wrap_cnt_0", frame_cnt, 4'd0);
        check("wrap_reg0", sreg(0), 32'd16);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/image_gen_frame_sync_ctrl.md
Name: image_gen_frame_sync_ctrl

Overview:
- Double-buffered configuration controller between the image_gen AXI4-Lite register file and the pixel image generator.
- Software register writes (paddle/ball positions, colours) land in a staging bank.
- The staging bank is copied to the live (shadow) bank only at frame start, and only after software has armed a commit. This gives tear-free Pong frame updates.
- Reports commit completion as a pulse, a sticky IRQ and a wrapping committed-frame counter.

Parameters:
- NUM_REGS, 4, number of 32-bit configuration registers; must be a power of two, 2..16.
- DATA_W, 32, register width in bits.
- RESET_VAL, 0, reset value loaded into every staging and shadow register.
- CNT_W, 16, width of the committed-frame counter.

Ports:
- ACLK  in  1  system clock; all logic rising-edge.
- ARESETN  in  1  synchronous active-low reset.
- wr_valid  in  1  staging-write request from the register file.
- wr_ready  out  1  staging write accepted when wr_valid && wr_ready.
- wr_addr  in  clog2(NUM_REGS)  staging register index.
- wr_data  in  DATA_W  write data.
- wr_strb  in  DATA_W/8  byte enables.
- commit_req  in  1  single-cycle arm request, from a software control-bit write.
- vsync_start  in  1  single-cycle pulse at the first line of vertical blanking, from the VGA timing block.
- irq_clr  in  1  single-cycle clear of the sticky IRQ.
- shadow_regs  out  NUM_REGS*DATA_W  live register bank; reg i occupies bits [i*DATA_W +: DATA_W].
- pending  out  1  high while a commit is armed or being applied.
- commit_done  out  1  one-cycle pulse when the shadow bank updates.
- irq  out  1  sticky commit interrupt.
- frame_cnt  out  CNT_W  number of completed commits; wraps.

Behaviour:
- Reset (ARESETN low at a rising edge):
  - all staging and shadow registers <= RESET_VAL;
  - state <= IDLE;
  - wr_ready=1, pending=0, commit_done=0, irq=0, frame_cnt=0.
  - Reset mid-ARMED or mid-APPLY aborts the commit; the shadow bank takes RESET_VAL, not the staged data.
- FSM states: IDLE, ARMED, APPLY.
- IDLE:
  - wr_ready=1; accepted writes merge per byte into staging[wr_addr].
  - commit_req=1 -> ARMED.
  - vsync_start is ignored in IDLE.
- ARMED:
  - wr_ready=0; the staging bank is frozen and writes stall with no loss.
  - pending=1.
  - vsync_start=1 -> APPLY. The shadow bank <= staging bank on this same edge, so new values are visible the cycle after the vsync_start pulse.
  - A repeated commit_req is ignored.
- APPLY (exactly one cycle):
  - commit_done=1, pending=1, wr_ready=0.
  - frame_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - irq set.
  - Next state is IDLE unconditionally.
- Simultaneous events:
  - commit_req with vsync_start in IDLE -> ARMED; the commit applies on the NEXT vsync_start, never the current one.
  - commit_req with wr_valid in IDLE: the write is accepted and included in the commit.
  - irq_clr in the same cycle as an irq set: the set wins and irq stays 1.
  - commit_req in APPLY is ignored.
- Latency:
  - write accepted -> staging updated at the next edge.
  - vsync_start in ARMED -> shadow visible +1 cycle; commit_done asserted +1 cycle.
- All outputs are registered. There is no combinational path from any input to wr_ready; it depends on state only.

Decomposition:
- Package image_gen_pkg:
  - typedef of the FSM state enum (IDLE, ARMED, APPLY);
  - constants NUM_REGS_DEF=4 and DATA_W_DEF=32;
  - register index localparams PADDLE_L, PADDLE_R, BALL_XY, COLOR.
- One sub-module, image_gen_reg_bank: NUM_REGS x DATA_W byte-strobed staging bank with parallel read-out. Instantiated once; the shadow bank is a plain register array in the top module.

Test Plan:
- Reset bank: write reg1=0xDEADBEEF (strb 0xF), no commit, pulse vsync_start twice -> shadow reg1 stays 0x00000000, frame_cnt=0, commit_done never asserts.
- Basic commit: write reg0=0x00010002, commit_req, vsync_start 20 cycles later -> shadow reg0=0x00010002 one cycle after vsync, commit_done one-cycle pulse, irq=1, frame_cnt=1.
- Byte strobe: staging reg2=0x11223344, write 0xAABBCCDD with strb 0x5, commit, vsync -> shadow reg2=0x11BB33DD.
- Stall while armed: commit_req, then wr_valid for reg3=0x55 -> wr_ready=0 until APPLY ends; the write completes in IDLE; the shadow holds the old reg3 until a second commit plus vsync.
- Same-cycle commit_req+vsync_start -> no update that frame; the update occurs on the following vsync_start. Then irq_clr in the same cycle as the APPLY-state irq set -> irq remains 1.
- Reset mid-ARMED: ARESETN low for one cycle while armed -> pending=0, shadow all 0, the next vsync_start produces no commit_done; also with CNT_W=4, 16 commits -> frame_cnt wraps to 0.
